// File: rtl/pong_game_ctrl.sv
// Pong round/match sequencer: start sync, serve delay, point pause,
// per-player scores, winning score and match restart.
`timescale 1ns/1ps
module pong_game_ctrl #(
   parameter int SCORE_WIDTH    = 4,
   parameter int WIN_SCORE      = 7,
   parameter int SERVE_TICKS    = 60,
   parameter int POINT_TICKS    = 30,
   parameter int TICK_CNT_WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   tick,
   input  logic                   start_n,
   input  logic                   score_left,
   input  logic                   score_right,
   output logic                   round_reset,
   output logic                   ball_enable,
   output logic                   serve_dir,
   output logic [SCORE_WIDTH-1:0] left_score,
   output logic [SCORE_WIDTH-1:0] right_score,
   output logic                   game_over,
   output logic                   winner,
   output logic [2:0]             state
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_SERVE = 3'd1;
   localparam logic [2:0] S_PLAY  = 3'd2;
   localparam logic [2:0] S_POINT = 3'd3;
   localparam logic [2:0] S_OVER  = 3'd4;

   localparam int SW = SCORE_WIDTH;
   localparam int TW = TICK_CNT_WIDTH;

   localparam logic [SW-1:0] WIN_S   = SW'(WIN_SCORE);
   localparam logic [SW-1:0] SMAX    = {SW{1'b1}};
   localparam logic [TW-1:0] SERVE_T = TW'(SERVE_TICKS);
   localparam logic [TW-1:0] POINT_T = TW'(POINT_TICKS);

   logic          s1_q, s2_q, s3_q;
   logic          start_evt;
   logic [2:0]    state_q, state_d;
   logic [TW-1:0] cnt_q, cnt_d, cnt_inc;
   logic [SW-1:0] left_q, left_d, right_q, right_d;
   logic          dir_q, dir_d;
   logic          over_q, over_d;
   logic          win_q, win_d;
   logic          rr_q, rr_d;
   logic          ben_q, ben_d;

   // start button: two-flop synchroniser plus edge-detect flop
   always_ff @(posedge clk) begin
      if (!reset) begin
         s1_q <= 1'b1;
         s2_q <= 1'b1;
         s3_q <= 1'b1;
      end else begin
         s1_q <= start_n;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign start_evt = s3_q & ~s2_q;
   assign cnt_inc   = cnt_q + TW'(1);

   // next-state logic for the round/match sequencer
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      left_d  = left_q;
      right_d = right_q;
      dir_d   = dir_q;
      over_d  = over_q;
      win_d   = win_q;
      rr_d    = 1'b0;
      case (state_q)
         S_IDLE, S_OVER: begin
            if (start_evt) begin
               state_d = S_SERVE;
               left_d  = '0;
               right_d = '0;
               over_d  = 1'b0;
               win_d   = 1'b0;
               rr_d    = 1'b1;
               cnt_d   = '0;
            end
         end
         S_SERVE: begin
            if (tick) begin
               if (cnt_inc >= SERVE_T) begin
                  state_d = S_PLAY;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
         S_PLAY: begin
            if (score_left || score_right) begin
               state_d = S_POINT;
               rr_d    = 1'b1;
               cnt_d   = '0;
               if (score_left && !score_right) begin
                  if (left_q != SMAX) left_d = left_q + SW'(1);
                  dir_d = 1'b1;
               end else if (score_right && !score_left) begin
                  if (right_q != SMAX) right_d = right_q + SW'(1);
                  dir_d = 1'b0;
               end
            end
         end
         S_POINT: begin
            if (tick) begin
               if (cnt_inc >= POINT_T) begin
                  cnt_d = '0;
                  if (left_q == WIN_S || right_q == WIN_S) begin
                     state_d = S_OVER;
                     over_d  = 1'b1;
                     win_d   = (right_q == WIN_S);
                  end else begin
                     state_d = S_SERVE;
                     rr_d    = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      ben_d = (state_d == S_PLAY);
   end

   // sequencer state and registered outputs
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         left_q  <= '0;
         right_q <= '0;
         dir_q   <= 1'b0;
         over_q  <= 1'b0;
         win_q   <= 1'b0;
         rr_q    <= 1'b0;
         ben_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         left_q  <= left_d;
         right_q <= right_d;
         dir_q   <= dir_d;
         over_q  <= over_d;
         win_q   <= win_d;
         rr_q    <= rr_d;
         ben_q   <= ben_d;
      end
   end

   assign state       = state_q;
   assign left_score  = left_q;
   assign right_score = right_q;
   assign serve_dir   = dir_q;
   assign game_over   = over_q;
   assign winner      = win_q;
   assign round_reset = rr_q;
   assign ball_enable = ben_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl with short serve/point delays
// and a winning score of two.
`timescale 1ns/1ps
module tb_pong_game_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       tick;
   logic       start_n;
   logic       score_left;
   logic       score_right;
   logic       round_reset;
   logic       ball_enable;
   logic       serve_dir;
   logic [3:0] left_score;
   logic [3:0] right_score;
   logic       game_over;
   logic       winner;
   logic [2:0] state;

   int checks = 0;
   int errors = 0;

   pong_game_ctrl #(
      .SCORE_WIDTH(4),
      .WIN_SCORE(2),
      .SERVE_TICKS(3),
      .POINT_TICKS(2),
      .TICK_CNT_WIDTH(8)
   ) dut (
      .clk(clk),
      .reset(reset),
      .tick(tick),
      .start_n(start_n),
      .score_left(score_left),
      .score_right(score_right),
      .round_reset(round_reset),
      .ball_enable(ball_enable),
      .serve_dir(serve_dir),
      .left_score(left_score),
      .right_score(right_score),
      .game_over(game_over),
      .winner(winner),
      .state(state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic clk_n(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic tick_once();
      tick = 1'b1;
      clk_n(1);
      tick = 1'b0;
   endtask

   task automatic serve_to_play(input string tag);
      tick_once();
      clk_n(3);
      tick_once();
      chk({tag, "_serve_wait"}, state, 1);
      chk({tag, "_ben_low"}, ball_enable, 0);
      clk_n(3);
      tick_once();
      chk({tag, "_play"}, state, 2);
      chk({tag, "_ben_high"}, ball_enable, 1);
      clk_n(3);
   endtask

   task automatic score(input logic l, input logic r);
      score_left  = l;
      score_right = r;
      clk_n(1);
      score_left  = 1'b0;
      score_right = 1'b0;
   endtask

   initial begin
      int n;
      reset       = 1'b0;
      tick        = 1'b0;
      start_n     = 1'b1;
      score_left  = 1'b0;
      score_right = 1'b0;
      clk_n(2);
      reset = 1'b1;
      clk_n(1);
      chk("rst_state", state, 0);
      chk("rst_rr", round_reset, 0);
      chk("rst_ben", ball_enable, 0);
      chk("rst_left", left_score, 0);
      chk("rst_right", right_score, 0);
      chk("rst_over", game_over, 0);
      chk("rst_dir", serve_dir, 0);

      start_n = 1'b0;
      clk_n(2);
      chk("start_lat2", state, 0);
      chk("start_lat2_rr", round_reset, 0);
      clk_n(1);
      chk("start_lat3", state, 1);
      chk("start_rr", round_reset, 1);
      n = 0;
      repeat (7) begin
         clk_n(1);
         n += int'(round_reset);
      end
      chk("held_rr", n, 0);
      chk("held_state", state, 1);
      start_n = 1'b1;
      clk_n(2);

      serve_to_play("s1");
      tick = 1'b1;
      score(1'b1, 1'b0);
      tick = 1'b0;
      chk("sl_left", left_score, 1);
      chk("sl_dir", serve_dir, 1);
      chk("sl_state", state, 3);
      chk("sl_rr", round_reset, 1);
      chk("sl_ben", ball_enable, 0);
      clk_n(1);
      chk("sl_rr_end", round_reset, 0);
      tick_once();
      chk("pt_wait", state, 3);
      clk_n(3);
      tick_once();
      chk("pt_serve", state, 1);
      chk("pt_rr", round_reset, 1);
      clk_n(3);

      serve_to_play("s2");
      score(1'b1, 1'b1);
      chk("both_state", state, 3);
      chk("both_left", left_score, 1);
      chk("both_right", right_score, 0);
      chk("both_dir", serve_dir, 1);
      chk("both_rr", round_reset, 1);
      tick_once();
      clk_n(3);
      tick_once();
      chk("both_serve", state, 1);
      clk_n(3);

      serve_to_play("s3");
      score(1'b0, 1'b1);
      chk("sr1_right", right_score, 1);
      chk("sr1_dir", serve_dir, 0);
      chk("sr1_state", state, 3);
      tick_once();
      clk_n(3);
      tick_once();
      chk("sr1_serve", state, 1);
      clk_n(3);

      serve_to_play("s4");
      score(1'b0, 1'b1);
      chk("sr2_right", right_score, 2);
      tick_once();
      clk_n(3);
      chk("sr2_not_over", game_over, 0);
      tick_once();
      chk("over_state", state, 4);
      chk("over_flag", game_over, 1);
      chk("over_winner", winner, 1);
      chk("over_right", right_score, 2);
      chk("over_left", left_score, 1);
      chk("over_rr", round_reset, 0);
      chk("over_ben", ball_enable, 0);
      clk_n(3);

      start_n = 1'b0;
      clk_n(3);
      chk("rs_state", state, 1);
      chk("rs_left", left_score, 0);
      chk("rs_right", right_score, 0);
      chk("rs_over", game_over, 0);
      chk("rs_rr", round_reset, 1);
      start_n = 1'b1;
      clk_n(3);

      serve_to_play("s5");
      score(1'b1, 1'b0);
      chk("p5_state", state, 3);
      tick        = 1'b1;
      score_left  = 1'b1;
      score_right = 1'b1;
      reset       = 1'b0;
      clk_n(1);
      tick        = 1'b0;
      score_left  = 1'b0;
      score_right = 1'b0;
      chk("mr_state", state, 0);
      chk("mr_left", left_score, 0);
      chk("mr_right", right_score, 0);
      chk("mr_rr", round_reset, 0);
      chk("mr_ben", ball_enable, 0);
      chk("mr_dir", serve_dir, 0);
      chk("mr_over", game_over, 0);
      chk("mr_winner", winner, 0);
      reset = 1'b1;
      clk_n(2);
      chk("mr_idle_hold", state, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
